// File: rtl/axis_pkt_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_pkt_gen_pkg : FSM states, LFSR taps and LFSR step helper      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package axis_pkt_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam logic [31:0] c_taps_dw8  = 32'h0000_00B8;
  localparam logic [31:0] c_taps_dw16 = 32'h0000_B400;
  localparam logic [31:0] c_taps_dw32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_taps(input int dw);
    case (dw)
      8:       return c_taps_dw8;
      16:      return c_taps_dw16;
      default: return c_taps_dw32;
    endcase
  endfunction

  // Galois right-shift step; caller keeps the value zero-extended to 32 bits.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur, input int dw);
    logic [31:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ lfsr_taps(dw);
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_lfsr : data-pattern register (counter or Galois LFSR)         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module axis_lfsr #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic          mode,
  input  logic [DW-1:0] seed,
  output logic [DW-1:0] data
);
  import axis_pkt_gen_pkg::*;

  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;
  logic [DW-1:0] w_seed_fix;

  always_comb begin
    // An all-zero LFSR state would lock up, so a zero seed becomes 1.
    w_seed_fix = (mode && (seed == '0)) ? DW'(1) : seed;
    data_d     = data_q;
    if (load) begin
      data_d = w_seed_fix;
    end else if (advance) begin
      data_d = mode ? DW'(lfsr_next(32'(data_q), DW)) : data_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end

  assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/axis_pkt_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_pkt_gen : AXI-Stream burst generator (packets, gaps, pattern) |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module axis_pkt_gen #(
  parameter int DW = 8,
  parameter int LW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] pkt_len,
  input  logic [7:0]    num_pkts,
  input  logic [3:0]    gap,
  input  logic          mode,
  input  logic [DW-1:0] seed,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic          busy,
  output logic          done
);
  import axis_pkt_gen_pkg::*;

  state_e        state_q, state_d;
  logic [LW-1:0] beat_cnt_q, beat_cnt_d;
  logic [7:0]    pkt_cnt_q, pkt_cnt_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    npkts_q, npkts_d;
  logic [3:0]    gap_cfg_q, gap_cfg_d;
  logic          mode_q, mode_d;

  logic          w_accept;
  logic          w_xfer;
  logic          w_last_beat;
  logic          w_pat_mode;

  assign w_last_beat = (beat_cnt_q == (len_q - LW'(1)));

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    len_d      = len_q;
    npkts_d    = npkts_q;
    gap_cfg_d  = gap_cfg_q;
    mode_d     = mode_q;
    w_accept   = 1'b0;
    w_xfer     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (pkt_len != '0) && (num_pkts != '0)) begin
          w_accept   = 1'b1;
          len_d      = pkt_len;
          npkts_d    = num_pkts;
          gap_cfg_d  = gap;
          mode_d     = mode;
          beat_cnt_d = '0;
          pkt_cnt_d  = '0;
          gap_cnt_d  = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_tready) begin
          w_xfer = 1'b1;
          if (w_last_beat) begin
            beat_cnt_d = '0;
            if (pkt_cnt_q == (npkts_q - 8'd1)) begin
              state_d = ST_FIN;
            end else begin
              pkt_cnt_d = pkt_cnt_q + 8'd1;
              if (gap_cfg_q != '0) begin
                gap_cnt_d = '0;
                state_d   = ST_GAP;
              end
            end
          end else begin
            beat_cnt_d = beat_cnt_q + LW'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == (gap_cfg_q - 4'd1)) begin
          gap_cnt_d = '0;
          state_d   = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      ST_FIN: begin
        beat_cnt_d = '0;
        pkt_cnt_d  = '0;
        gap_cnt_d  = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      len_q      <= '0;
      npkts_q    <= '0;
      gap_cfg_q  <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      len_q      <= len_d;
      npkts_q    <= npkts_d;
      gap_cfg_q  <= gap_cfg_d;
      mode_q     <= mode_d;
    end
  end

  // The seed is loaded with the incoming mode; later steps use the latched one.
  assign w_pat_mode = w_accept ? mode : mode_q;

  axis_lfsr #(
    .DW (DW)
  ) u_pattern (
    .clk     (clk),
    .rst     (rst),
    .load    (w_accept),
    .advance (w_xfer),
    .mode    (w_pat_mode),
    .seed    (seed),
    .data    (m_tdata)
  );

  assign m_tvalid = (state_q == ST_SEND);
  assign m_tlast  = m_tvalid && w_last_beat;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FIN);

endmodule
`default_nettype wire
